image_frame_unpacker: RTL and testbench

IMAGE_FRAME_UNPACKER -- requirements
Module: image_frame_unpacker

---
 rtl/image_frame_unpacker.sv | 143 ++++++++++++++
 tb/tb_image_frame_unpacker.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/image_frame_unpacker.sv
// Unpacks PIX_PER_WORD-pixel words into a one-pixel-per-cycle stream for a rows x cols frame.
// Define IMAGE_FRAME_UNPACKER_COORD_EN to get live pix_x/pix_y counters; otherwise they are tied to 0.
module image_frame_unpacker #(
  parameter int PIX_W        = 8,
  parameter int PIX_PER_WORD = 8,
  parameter int DIM_W        = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic [DIM_W-1:0]              rows,
  input  logic [DIM_W-1:0]              cols,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [PIX_W*PIX_PER_WORD-1:0] in_data,
  output logic                          pix_valid,
  input  logic                          pix_ready,
  output logic [PIX_W-1:0]              pix_data,
  output logic [DIM_W-1:0]              pix_x,
  output logic [DIM_W-1:0]              pix_y,
  output logic                          busy,
  output logic                          frame_done
);

  localparam int TOT_W  = 2 * DIM_W;
  localparam int WORD_W = PIX_W * PIX_PER_WORD;
  localparam int LEFT_W = $clog2(PIX_PER_WORD + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_reg, state_next;
  logic [TOT_W-1:0]   total;
  logic [TOT_W-1:0]   load_rem_reg;   // pixels not yet loaded into the holding register
  logic [TOT_W-1:0]   out_rem_reg;    // pixels not yet transferred downstream
  logic [WORD_W-1:0]  hold_reg;
  logic [WORD_W-1:0]  hold_shifted;
  logic [LEFT_W-1:0]  left_reg;
  logic [LEFT_W-1:0]  word_left;
  logic               run_st;
  logic               pix_xfer;
  logic               word_acc;
  logic               last_xfer;

  assign total     = TOT_W'(rows) * TOT_W'(cols);
  assign run_st    = (state_reg == RUN);
  assign pix_xfer  = run_st && (left_reg != '0) && pix_ready;
  assign word_acc  = in_valid && in_ready;
  assign last_xfer = pix_xfer && (out_rem_reg == TOT_W'(1));
  // Only the pixels still owed by the frame count; the rest of the final word is dropped.
  assign word_left = (load_rem_reg >= TOT_W'(PIX_PER_WORD)) ? LEFT_W'(PIX_PER_WORD)
                                                            : load_rem_reg[LEFT_W-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < PIX_PER_WORD; gi++) begin : g_lane
      if (gi < PIX_PER_WORD - 1) begin : g_mid
        assign hold_shifted[gi*PIX_W +: PIX_W] = hold_reg[(gi+1)*PIX_W +: PIX_W];
      end else begin : g_top
        assign hold_shifted[gi*PIX_W +: PIX_W] = '0;
      end
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = (total != '0) ? RUN : DONE;
      RUN:     if (last_xfer) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Refill the holding register in the same cycle its last pixel leaves.
  always_comb begin
    in_ready   = run_st && (load_rem_reg != '0) &&
                 ((left_reg == '0) || ((left_reg == LEFT_W'(1)) && pix_xfer));
    pix_valid  = run_st && (left_reg != '0);
    busy       = (state_reg == RUN) || (state_reg == DONE);
    frame_done = (state_reg == DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      load_rem_reg <= '0;
      out_rem_reg  <= '0;
      hold_reg     <= '0;
      left_reg     <= '0;
    end else if ((state_reg == IDLE) && start) begin
      load_rem_reg <= total;
      out_rem_reg  <= total;
      hold_reg     <= '0;
      left_reg     <= '0;
    end else begin
      if (word_acc) begin
        hold_reg     <= in_data;
        left_reg     <= word_left;
        load_rem_reg <= load_rem_reg - TOT_W'(word_left);
      end else if (pix_xfer) begin
        hold_reg <= hold_shifted;
        left_reg <= left_reg - LEFT_W'(1);
      end
      if (pix_xfer) out_rem_reg <= out_rem_reg - TOT_W'(1);
    end
  end

  assign pix_data = hold_reg[PIX_W-1:0];

`ifdef IMAGE_FRAME_UNPACKER_COORD_EN
  logic [DIM_W-1:0] cols_reg, x_reg, y_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cols_reg <= '0;
      x_reg    <= '0;
      y_reg    <= '0;
    end else if ((state_reg == IDLE) && start) begin
      cols_reg <= cols;
      x_reg    <= '0;
      y_reg    <= '0;
    end else if (pix_xfer) begin
      if (x_reg == cols_reg - DIM_W'(1)) begin
        x_reg <= '0;
        y_reg <= y_reg + DIM_W'(1);
      end else begin
        x_reg <= x_reg + DIM_W'(1);
      end
    end
  end

  assign pix_x = x_reg;
  assign pix_y = y_reg;
`else
  assign pix_x = '0;
  assign pix_y = '0;
`endif

endmodule

// File: tb/tb_image_frame_unpacker.sv
// Directed bench for image_frame_unpacker: frame table plus zero-size, stall and mid-frame reset sequences.
module tb_image_frame_unpacker;
  localparam int PIX_W = 8;
  localparam int PPW   = 8;
  localparam int DIM_W = 16;

  logic                   clock = 1'b0;
  logic                   reset = 1'b1;
  logic                   start = 1'b0;
  logic [DIM_W-1:0]       rows  = '0;
  logic [DIM_W-1:0]       cols  = '0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [PIX_W*PPW-1:0]   in_data = '0;
  logic                   pix_valid;
  logic                   pix_ready = 1'b0;
  logic [PIX_W-1:0]       pix_data;
  logic [DIM_W-1:0]       pix_x, pix_y;
  logic                   busy, frame_done;

  int checks = 0;
  int passed = 0;

  image_frame_unpacker #(.PIX_W(PIX_W), .PIX_PER_WORD(PPW), .DIM_W(DIM_W)) dut (
    .clock(clock), .reset(reset), .start(start), .rows(rows), .cols(cols),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_x(pix_x), .pix_y(pix_y), .busy(busy), .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         r;
    int         c;
    int         exp_words;
    int         exp_pix;
    logic [3:0] rdy_pat;
    logic [3:0] vld_pat;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, wanted %0d", name, act, exp);
  endtask

  function automatic logic [7:0] pix_val(input int n);
    return 8'((n * 7 + (n >> 8)) & 255);
  endfunction

  function automatic logic [PIX_W*PPW-1:0] word_of(input int w);
    logic [PIX_W*PPW-1:0] wd;
    for (int k = 0; k < PPW; k++) wd[k*PIX_W +: PIX_W] = pix_val(w * PPW + k);
    return wd;
  endfunction

  // Must be entered in the low clock phase; returns in the low phase.
  task automatic run_frame(input string tag, input int r, input int c, input int exp_words,
                           input int exp_pix, input logic [3:0] rdy_pat,
                           input logic [3:0] vld_pat, input int stop_at);
    int total, need, widx, pidx, cyc, budget, last_cyc, done_cyc, loaded, ml, ex, ey;
    int data_err, xy_err, stall_err, hs_err, busy_err;
    bit prev_stall, exp_rdy, exp_vld;
    logic [PIX_W-1:0] prev_d;
    logic [DIM_W-1:0] prev_x, prev_y, want_x, want_y;
    total = r * c;  need = (total + PPW - 1) / PPW;  budget = total * 4 + 40;
    widx = 0; pidx = 0; cyc = 0; last_cyc = -10; done_cyc = -1; ex = 0; ey = 0;
    data_err = 0; xy_err = 0; stall_err = 0; hs_err = 0; busy_err = 0; prev_stall = 0;
    prev_d = '0; prev_x = '0; prev_y = '0;
    rows = DIM_W'(r); cols = DIM_W'(c); start = 1'b1;
    @(posedge clock);
    while (cyc < budget) begin
      @(negedge clock);
      rows = 16'd7; cols = 16'd1;           // start stays high: must be ignored outside IDLE
      pix_ready = rdy_pat[cyc % 4];
      in_valid  = vld_pat[cyc % 4];
      in_data   = word_of(widx);
      #1;
      if (!busy) busy_err++;
      loaded  = (widx * PPW < total) ? widx * PPW : total;
      ml      = loaded - pidx;
      exp_vld = (ml > 0);
      exp_rdy = (widx < need) && ((ml == 0) || (ml == 1 && pix_ready));
      if (in_ready !== exp_rdy || pix_valid !== exp_vld) hs_err++;
      if (prev_stall && (pix_valid !== 1'b1 || pix_data !== prev_d ||
                         pix_x !== prev_x || pix_y !== prev_y)) stall_err++;
      if (pix_valid && pix_ready) begin
        if (pix_data !== pix_val(pidx)) data_err++;
`ifdef IMAGE_FRAME_UNPACKER_COORD_EN
        want_x = DIM_W'(ex); want_y = DIM_W'(ey);
`else
        want_x = '0; want_y = '0;
`endif
        if (pix_x !== want_x || pix_y !== want_y) xy_err++;
        if (ex == c - 1) begin ex = 0; ey++; end else ex++;
        pidx++;
        last_cyc = cyc;
      end
      prev_stall = pix_valid && !pix_ready;
      prev_d = pix_data; prev_x = pix_x; prev_y = pix_y;
      if (in_valid && in_ready) widx++;
      if (frame_done) begin done_cyc = cyc; start = 1'b0; break; end
      if (stop_at > 0 && pidx >= stop_at) break;
      cyc++;
    end
    if (stop_at > 0) begin
      check({tag, " data before reset"}, data_err, 0);
      check({tag, " pixels before reset"}, pidx, stop_at);
      return;
    end
    check({tag, " words accepted"}, widx, exp_words);
    check({tag, " pixels out"}, pidx, exp_pix);
    check({tag, " pixel data errors"}, data_err, 0);
    check({tag, " coord errors"}, xy_err, 0);
    check({tag, " stall stability errors"}, stall_err, 0);
    check({tag, " handshake errors"}, hs_err, 0);
    check({tag, " busy errors"}, busy_err, 0);
    check({tag, " done cycles after last pixel"}, done_cyc - last_cyc, 1);
    @(negedge clock);
    in_valid = 1'b1; pix_ready = 1'b1;
    #1;
    check({tag, " idle after done {busy,done,in_ready,pix_valid}"},
          {busy, frame_done, in_ready, pix_valid}, 0);
  endtask

  vec_t vecs[7];
  int   fd_seen;

  initial begin
    vecs[0] = '{r: 3,  c: 3,   exp_words: 2,    exp_pix: 9,    rdy_pat: 4'b1111, vld_pat: 4'b1111};
    vecs[1] = '{r: 4,  c: 4,   exp_words: 2,    exp_pix: 16,   rdy_pat: 4'b1001, vld_pat: 4'b1111};
    vecs[2] = '{r: 2,  c: 4,   exp_words: 1,    exp_pix: 8,    rdy_pat: 4'b1111, vld_pat: 4'b0101};
    vecs[3] = '{r: 1,  c: 1,   exp_words: 1,    exp_pix: 1,    rdy_pat: 4'b1111, vld_pat: 4'b1111};
    vecs[4] = '{r: 2,  c: 3,   exp_words: 1,    exp_pix: 6,    rdy_pat: 4'b0110, vld_pat: 4'b1111};
    vecs[5] = '{r: 5,  c: 7,   exp_words: 5,    exp_pix: 35,   rdy_pat: 4'b1011, vld_pat: 4'b1101};
    vecs[6] = '{r: 96, c: 103, exp_words: 1236, exp_pix: 9888, rdy_pat: 4'b1111, vld_pat: 4'b1111};

    #12;
    check("reset outputs zero", {in_ready, pix_valid, pix_data, pix_x, pix_y, busy, frame_done}, 0);
    @(negedge clock);
    reset = 1'b0;

    // Zero-size frame: straight to DONE, one-cycle pulse, no word requested.
    rows = 16'd0; cols = 16'd5; start = 1'b1;
    #1 check("zero frame done before edge", frame_done, 0);
    @(negedge clock);
    start = 1'b0;
    #1;
    check("zero frame done pulse", frame_done, 1);
    check("zero frame busy", busy, 1);
    check("zero frame in_ready/pix_valid", {in_ready, pix_valid}, 0);
    @(negedge clock);
    #1 check("zero frame back to idle {busy,done}", {busy, frame_done}, 0);
    @(negedge clock);

    for (int i = 0; i < 7; i++)
      run_frame($sformatf("frame%0d %0dx%0d", i, vecs[i].r, vecs[i].c), vecs[i].r, vecs[i].c,
                vecs[i].exp_words, vecs[i].exp_pix, vecs[i].rdy_pat, vecs[i].vld_pat, 0);

    // Reset mid-frame at pixel 40, then a new frame on the first cycle after release.
    @(negedge clock);
    run_frame("rst96x103", 96, 103, 1236, 9888, 4'b1111, 4'b1111, 40);
    #1 reset = 1'b1;
    #1 check("async reset outputs zero",
             {in_ready, pix_valid, pix_data, pix_x, pix_y, busy, frame_done}, 0);
    fd_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      #1 if (frame_done) fd_seen++;
    end
    check("no frame_done across reset", fd_seen, 0);
    @(negedge clock);
    reset = 1'b0;
    run_frame("after reset 2x4", 2, 4, 1, 8, 4'b1111, 4'b1111, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: got running, wanted finished");
    $fatal(1, "timeout");
  end
endmodule
